// File: rtl/exec_seq.sv
// Execution-state sequencer: steps an instruction through one-hot execution
// states, runs memory/I/O handshakes with a wait timeout, and hands off to the FPU.
module exec_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic __clk,
  input  logic clr,
  input  logic ir_valid,
  input  logic step,
  input  logic ewz,
  input  logic ew$,
  input  logic ewe,
  input  logic ewa,
  input  logic ewp,
  input  logic ewr,
  input  logic ewm,
  input  logic eww,
  input  logic ewx,
  input  logic ekc_1,
  input  logic ekc_2,
  input  logic efp,
  input  logic mem_ok,
  input  logic io_ok,
  input  logic fp_done,
  input  logic abort,
  output logic pp,
  output logic we,
  output logic wr,
  output logic ww,
  output logic wm,
  output logic wp,
  output logic wx,
  output logic wa,
  output logic wz,
  output logic w$,
  output logic idle,
  output logic kc,
  output logic mem_req,
  output logic mem_wr,
  output logic io_req,
  output logic fp_start,
  output logic alarm,
  output logic seq_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_PP, S_WE, S_WR, S_WW, S_WM, S_WP, S_WX, S_WA, S_WZ, S_WD, S_FP, S_KC
  } state_e;

  state_e             state_q, state_d, tgt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               alarm_q, alarm_d;
  logic               seq_err_q, seq_err_d;
  logic               fp_start_q, fp_start_d;
  logic               adv, wait_st, enter;
  logic [8:0]         ew;

  assign ew = {ewz, ew$, ewe, ewa, ewp, ewr, ewm, eww, ewx};

  // Target state of a single enter request; only used when ew is one-hot.
  always_comb begin
    tgt = S_IDLE;
    if (ewz) tgt = S_WZ;
    if (ew$) tgt = S_WD;
    if (ewe) tgt = S_WE;
    if (ewa) tgt = S_WA;
    if (ewp) tgt = S_WP;
    if (ewr) tgt = S_WR;
    if (ewm) tgt = S_WM;
    if (eww) tgt = S_WW;
    if (ewx) tgt = S_WX;
  end

  always_comb begin
    state_d    = state_q;
    alarm_d    = alarm_q;
    seq_err_d  = seq_err_q;
    adv        = 1'b0;
    wait_st    = 1'b0;
    case (state_q)
      S_IDLE:  if (ir_valid) state_d = S_PP;
      S_WR,
      S_WW: begin
        wait_st = 1'b1;
        adv     = mem_ok;
      end
      S_WM: begin
        wait_st = 1'b1;
        adv     = io_ok;
      end
      S_FP:    adv = fp_done;
      S_KC:    state_d = ir_valid ? S_PP : S_IDLE;
      default: adv = step;
    endcase

    if (adv) begin
      if (state_q == S_FP || ekc_1 || ekc_2) begin
        state_d = S_KC;
      end else if ($onehot(ew) && !efp) begin
        state_d = tgt;
      end else if (efp && ew == 9'd0) begin
        state_d = S_FP;
      end else begin
        seq_err_d = 1'b1;
        state_d   = S_KC;
      end
    end else if (wait_st && (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
      alarm_d = 1'b1;
      state_d = S_KC;
    end

    // Cancel wins over every decision made above.
    if (abort) begin
      state_d   = S_IDLE;
      alarm_d   = alarm_q;
      seq_err_d = seq_err_q;
    end

    // Any transition, including re-entry at an advance point, restarts the wait count.
    enter = adv | abort | (state_d != state_q);
    if (enter)        cnt_d = '0;
    else if (wait_st) cnt_d = cnt_q + CNT_W'(1);
    else              cnt_d = cnt_q;

    fp_start_d = (state_d == S_FP) && (state_q != S_FP);
  end

  always_ff @(posedge __clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alarm_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      fp_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alarm_q    <= alarm_d;
      seq_err_q  <= seq_err_d;
      fp_start_q <= fp_start_d;
    end
  end

  assign idle     = (state_q == S_IDLE);
  assign pp       = (state_q == S_PP);
  assign we       = (state_q == S_WE);
  assign wr       = (state_q == S_WR);
  assign ww       = (state_q == S_WW);
  assign wm       = (state_q == S_WM);
  assign wp       = (state_q == S_WP);
  assign wx       = (state_q == S_WX);
  assign wa       = (state_q == S_WA);
  assign wz       = (state_q == S_WZ);
  assign w$       = (state_q == S_WD);
  assign kc       = (state_q == S_KC);
  assign mem_req  = (state_q == S_WR) || (state_q == S_WW);
  assign mem_wr   = (state_q == S_WW);
  assign io_req   = (state_q == S_WM);
  assign fp_start = fp_start_q;
  assign alarm    = alarm_q;
  assign seq_err  = seq_err_q;

endmodule

// File: doc/exec_seq.md
EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 Parameter: TIMEOUT, default 255; the maximum number of handshake wait cycles, range 1..255.
REQ-002 Ports (name, direction, width, meaning):
- __clk  in  1  sole clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- ir_valid  in  1  decoder holds a valid instruction; starts an instruction cycle.
- step  in  1  one-cycle pulse ending the current micro-step in non-handshake states.
- ewz, ew$, ewe, ewa, ewp, ewr, ewm, eww, ewx  in  1 each  enter-state requests from the decoder.
- ekc_1, ekc_2  in  1 each  cycle-end requests.
- efp  in  1  hand-off to the floating-point unit.
- mem_ok  in  1  memory handshake acknowledge.
- io_ok  in  1  I/O handshake acknowledge.
- fp_done  in  1  floating-point unit finished.
- abort  in  1  cancel the current instruction.
- pp, we, wr, ww, wm, wp, wx, wa, wz, w$  out  1 each  one-hot execution-state outputs.
- idle  out  1  no instruction in progress.
- kc  out  1  cycle-end pulse.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory request is a write.
- io_req  out  1  I/O request.
- fp_start  out  1  pulse starting the floating-point unit.
- alarm  out  1  sticky handshake timeout.
- seq_err  out  1  sticky sequencing error.
REQ-003 The clock and reset shall be exactly as stated: one clock, __clk; reset clr is synchronous and active-high.

Function
REQ-004 The state set shall be IDLE, PP, WE, WR, WW, WM, WP, WX, WA, WZ, W$, FP, KC, held in a single registered state.
REQ-005 Each of the outputs idle, pp, we, wr, ww, wm, wp, wx, wa, wz, w$ shall be high only while in its same-named state, and exactly one of them or none (in FP and KC) shall be high.
REQ-006 From IDLE with ir_valid high, the next state shall be PP; otherwise the block shall remain in IDLE.
REQ-007 A state shall be left at its "advance point", defined as follows:
- PP, WE, WP, WX, WA, WZ, W$: step high.
- WR, WW: mem_ok high.
- WM: io_ok high.
- FP: fp_done high.
REQ-008 At an advance point, if ekc_1 or ekc_2 is high, the next state shall be KC, regardless of any ew* request.
REQ-009 At an advance point with no cycle-end request and exactly one ew* high, the next state shall be the named state; re-entering the current state is legal.
REQ-010 At an advance point with no cycle-end request and efp high together with zero ew* high, the next state shall be FP.
REQ-011 At an advance point with no cycle-end request, if zero or more than one of {ew*, efp} are high, seq_err shall be set and the next state shall be KC.
REQ-012 FP shall always exit to KC; fp_start shall be high for exactly the first cycle in FP.
REQ-013 KC shall last one cycle, during which kc is high; the next state shall be IDLE, or PP directly if ir_valid is high in that cycle.
REQ-014 Handshake outputs shall be combinational from the state:
- mem_req high in WR and WW.
- mem_wr high only in WW.
- io_req high only in WM.
REQ-015 An 8-bit wait counter shall clear on every state entry and increment each cycle spent in WR, WW or WM without the acknowledge; when it reaches TIMEOUT, alarm shall be set and the next state shall be KC.
REQ-016 An acknowledge in the same cycle the counter reaches TIMEOUT shall win: normal advance, no alarm.
REQ-017 abort shall force the next state to IDLE from any state; it shall take priority over all else except clr, drop mem_req/io_req on the next cycle, and generate no kc.
REQ-018 alarm and seq_err shall be sticky until clr; they shall not block later instructions.
REQ-019 Inputs step, mem_ok, io_ok and fp_done shall be ignored in states where they are not the advance point.

Reset
REQ-020 With clr high at an edge, the next state shall be IDLE, counter 0, and alarm = seq_err = 0.
REQ-021 After clr, idle = 1 and every other output = 0.
REQ-022 clr shall override abort and any in-flight handshake; mem_req shall be 0 in the first cycle after reset.

Verification
REQ-023 Bench scenarios:
- Straight path: ir_valid; step with ewa; step with ewp; step with ekc_2 -> PP, WA, WP, KC (kc = 1 for 1 cycle), IDLE; no flags set.
- Memory wait: enter WR, mem_ok after 5 cycles with eww -> mem_req = 1 for 6 cycles, mem_wr = 0; then WW with mem_wr = 1 until mem_ok with ekc_1 -> KC.
- Timeout: TIMEOUT = 4, WM with io_ok never high -> alarm = 1 on the cycle after the 4th wait cycle, then KC, IDLE; next instruction runs normally with alarm still 1.
- Conflict: in PP, step with ewa = ewe = 1 -> seq_err = 1, next state KC; step with no requests -> seq_err also set.
- Float: in PP, step with efp -> FP, fp_start pulse 1 cycle; fp_done after 10 cycles -> KC, IDLE.
- Abort/reset: abort in WW while waiting -> IDLE next cycle, mem_req = 0, kc never 1; clr mid-WR -> all outputs at reset values next cycle.
